// File: rtl/exe_mem_status_stage.sv
// EXE->MEM pipeline register plus the architectural status register (SR).
// Captures the ALU result, store data, destination and control enables at the end of EXE,
// owns the {N,Z,C,V} status register (updated only by S-suffixed instructions) and evaluates
// the ARM condition field against the current SR for ID-stage gating.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   Freeze              memory stall; holds every register
//   EXE_Valid           EXE holds a real instruction
//   *_In                fields and enables presented by EXE
//   Cond                ID-stage condition field
//   MEM_Valid .. Dest   registered pipeline outputs towards MEM
//   SR                  status register {N,Z,C,V}; SR[1] is the carry fed back to the ALU
//   Cond_Pass           combinational condition evaluation against SR
//   Illegal             one-cycle pulse after a combined load+store was rejected
module exe_mem_status_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Freeze,
  input  logic              EXE_Valid,
  input  logic              WB_EN_In,
  input  logic              MEM_R_EN_In,
  input  logic              MEM_W_EN_In,
  input  logic              S_In,
  input  logic [DATA_W-1:0] ALU_Res_In,
  input  logic [3:0]        Status_In,
  input  logic [DATA_W-1:0] Val_Rm_In,
  input  logic [DEST_W-1:0] Dest_In,
  input  logic [3:0]        Cond,
  output logic              MEM_Valid,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic [DATA_W-1:0] ALU_Res,
  output logic [DATA_W-1:0] Val_Rm,
  output logic [DEST_W-1:0] Dest,
  output logic [3:0]        SR,
  output logic              Cond_Pass,
  output logic              Illegal
);

  logic              valid_q, valid_d;
  logic              wb_en_q, wb_en_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic [DATA_W-1:0] val_rm_q, val_rm_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [3:0]        sr_q, sr_d;
  logic              illegal_q, illegal_d;

  logic rw_conflict;
  assign rw_conflict = MEM_R_EN_In & MEM_W_EN_In;

  always_comb begin
    valid_d    = valid_q;
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    mem_w_en_d = mem_w_en_q;
    alu_res_d  = alu_res_q;
    val_rm_d   = val_rm_q;
    dest_d     = dest_q;
    sr_d       = sr_q;
    illegal_d  = 1'b0;
    if (!Freeze) begin
      if (EXE_Valid && !rw_conflict) begin
        valid_d    = 1'b1;
        wb_en_d    = WB_EN_In;
        mem_r_en_d = MEM_R_EN_In;
        mem_w_en_d = MEM_W_EN_In;
        alu_res_d  = ALU_Res_In;
        val_rm_d   = Val_Rm_In;
        dest_d     = Dest_In;
        if (S_In) begin
          sr_d = Status_In;
        end
      end else begin
        // Bubble or rejected R+W: kill enables, keep data fields and SR.
        valid_d    = 1'b0;
        wb_en_d    = 1'b0;
        mem_r_en_d = 1'b0;
        mem_w_en_d = 1'b0;
        illegal_d  = EXE_Valid & rw_conflict;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
      sr_q       <= 4'b0000;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= val_rm_d;
      dest_q     <= dest_d;
      sr_q       <= sr_d;
      illegal_q  <= illegal_d;
    end
  end

  // Condition evaluation uses the registered SR only (no bypass of Status_In).
  logic n_flag, z_flag, c_flag, v_flag;
  assign n_flag = sr_q[3];
  assign z_flag = sr_q[2];
  assign c_flag = sr_q[1];
  assign v_flag = sr_q[0];

  always_comb begin
    Cond_Pass = 1'b0;
    case (Cond)
      4'b0000: Cond_Pass = z_flag;
      4'b0001: Cond_Pass = ~z_flag;
      4'b0010: Cond_Pass = c_flag;
      4'b0011: Cond_Pass = ~c_flag;
      4'b0100: Cond_Pass = n_flag;
      4'b0101: Cond_Pass = ~n_flag;
      4'b0110: Cond_Pass = v_flag;
      4'b0111: Cond_Pass = ~v_flag;
      4'b1000: Cond_Pass = c_flag & ~z_flag;
      4'b1001: Cond_Pass = ~c_flag | z_flag;
      4'b1010: Cond_Pass = (n_flag == v_flag);
      4'b1011: Cond_Pass = (n_flag != v_flag);
      4'b1100: Cond_Pass = ~z_flag & (n_flag == v_flag);
      4'b1101: Cond_Pass = z_flag | (n_flag != v_flag);
      4'b1110: Cond_Pass = 1'b1;
      default: Cond_Pass = 1'b0;
    endcase
  end

  assign MEM_Valid = valid_q;
  assign WB_EN     = wb_en_q;
  assign MEM_R_EN  = mem_r_en_q;
  assign MEM_W_EN  = mem_w_en_q;
  assign ALU_Res   = alu_res_q;
  assign Val_Rm    = val_rm_q;
  assign Dest      = dest_q;
  assign SR        = sr_q;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_exe_mem_status_stage.sv
`timescale 1ns/1ps
module tb_exe_mem_status_stage;

  logic        clk = 1'b0;
  logic        rst_n, Freeze, EXE_Valid, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, S_In;
  logic [31:0] ALU_Res_In, Val_Rm_In;
  logic [3:0]  Status_In, Dest_In, Cond;
  logic        MEM_Valid, WB_EN, MEM_R_EN, MEM_W_EN, Cond_Pass, Illegal;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest, SR;

  exe_mem_status_stage #(.DATA_W(32), .DEST_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Freeze(Freeze), .EXE_Valid(EXE_Valid),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In), .S_In(S_In),
    .ALU_Res_In(ALU_Res_In), .Status_In(Status_In), .Val_Rm_In(Val_Rm_In), .Dest_In(Dest_In),
    .Cond(Cond), .MEM_Valid(MEM_Valid), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .SR(SR),
    .Cond_Pass(Cond_Pass), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Expected architectural state of the stage.
  logic        m_valid, m_wb, m_r, m_w, m_ill;
  logic [31:0] m_alu, m_rm;
  logic [3:0]  m_dest, m_sr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Condition table: pairs share a base predicate, odd codes invert it.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] sr);
    logic n, z, cy, v, base;
    {n, z, cy, v} = sr;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  // Advance the model by one edge using the inputs currently applied, then let the edge pass.
  task automatic cycle();
    logic        valid_n, wb_n, r_n, w_n, ill_n;
    logic [31:0] alu_n, rm_n;
    logic [3:0]  dest_n, sr_n;
    {valid_n, wb_n, r_n, w_n, alu_n, rm_n, dest_n, sr_n} =
      {m_valid, m_wb, m_r, m_w, m_alu, m_rm, m_dest, m_sr};
    ill_n = 1'b0;
    if (!rst_n) begin
      {valid_n, wb_n, r_n, w_n, alu_n, rm_n, dest_n, sr_n} = '0;
    end else if (!Freeze) begin
      if (EXE_Valid && !(MEM_R_EN_In && MEM_W_EN_In)) begin
        {valid_n, wb_n, r_n, w_n} = {1'b1, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In};
        {alu_n, rm_n, dest_n} = {ALU_Res_In, Val_Rm_In, Dest_In};
        if (S_In) sr_n = Status_In;
      end else begin
        {valid_n, wb_n, r_n, w_n} = 4'b0000;
        ill_n = EXE_Valid;
      end
    end
    @(posedge clk);
    #1;
    {m_valid, m_wb, m_r, m_w, m_alu, m_rm, m_dest, m_sr, m_ill} =
      {valid_n, wb_n, r_n, w_n, alu_n, rm_n, dest_n, sr_n, ill_n};
  endtask

  task automatic drive(input logic v, input logic wb, input logic r, input logic w,
                       input logic s, input logic [31:0] alu, input logic [3:0] st,
                       input logic [31:0] rm, input logic [3:0] d);
    {EXE_Valid, WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, S_In} = {v, wb, r, w, s};
    {ALU_Res_In, Status_In, Val_Rm_In, Dest_In} = {alu, st, rm, d};
  endtask

  // Compare process: checks every output against the model at each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("MEM_Valid", {31'd0, MEM_Valid}, {31'd0, m_valid});
      check("WB_EN", {31'd0, WB_EN}, {31'd0, m_wb});
      check("MEM_R_EN", {31'd0, MEM_R_EN}, {31'd0, m_r});
      check("MEM_W_EN", {31'd0, MEM_W_EN}, {31'd0, m_w});
      check("ALU_Res", ALU_Res, m_alu);
      check("Val_Rm", Val_Rm, m_rm);
      check("Dest", {28'd0, Dest}, {28'd0, m_dest});
      check("SR", {28'd0, SR}, {28'd0, m_sr});
      check("Illegal", {31'd0, Illegal}, {31'd0, m_ill});
      check("Cond_Pass", {31'd0, Cond_Pass}, {31'd0, cond_ok(Cond, m_sr)});
    end
  end

  initial begin
    rst_n = 1'b0; Freeze = 1'b0; Cond = 4'b1110;
    drive(0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 4'h0);
    {m_valid, m_wb, m_r, m_w, m_alu, m_rm, m_dest, m_sr, m_ill} = '0;
    cycle();
    chk_en = 1'b1;

    // Preload SR=1111 and some data, then reset under Freeze.
    rst_n = 1'b1;
    drive(1, 1, 0, 1, 1, 32'hDEAD_BEEF, 4'b1111, 32'h1234_5678, 4'd9);
    cycle();
    check("lit_preload_sr", {28'd0, SR}, 32'hF);
    rst_n = 1'b0; Freeze = 1'b1;
    cycle();
    check("lit_reset_sr", {28'd0, SR}, 32'h0);
    check("lit_reset_alu", ALU_Res, 32'h0);
    check("lit_reset_valid", {31'd0, MEM_Valid}, 32'h0);
    Cond = 4'b1110; #1 check("lit_reset_al", {31'd0, Cond_Pass}, 32'h1);
    Cond = 4'b0000; #1 check("lit_reset_eq", {31'd0, Cond_Pass}, 32'h0);

    // Capture with flag update.
    rst_n = 1'b1; Freeze = 1'b0;
    drive(1, 1, 0, 0, 1, 32'h0000_0040, 4'b0100, 32'h0, 4'd5);
    cycle();
    check("lit_cap_alu", ALU_Res, 32'h40);
    check("lit_cap_dest", {28'd0, Dest}, 32'h5);
    check("lit_cap_valid", {31'd0, MEM_Valid}, 32'h1);
    check("lit_cap_sr", {28'd0, SR}, 32'h4);
    Cond = 4'b0000; #1 check("lit_cap_eq", {31'd0, Cond_Pass}, 32'h1);
    Cond = 4'b0001; #1 check("lit_cap_ne", {31'd0, Cond_Pass}, 32'h0);

    // Non-S instruction leaves SR alone; S instruction updates it.
    drive(1, 1, 0, 0, 0, 32'h0000_0044, 4'b1010, 32'h0, 4'd6);
    cycle();
    check("lit_nos_sr", {28'd0, SR}, 32'h4);
    drive(1, 1, 0, 0, 1, 32'h0000_0048, 4'b1001, 32'h0, 4'd7);
    cycle();
    check("lit_s_sr", {28'd0, SR}, 32'h9);
    // SR=1001: N=1, V=1, so GE holds and LT does not.
    Cond = 4'b1010; #1 check("lit_ge", {31'd0, Cond_Pass}, 32'h1);
    Cond = 4'b1011; #1 check("lit_lt", {31'd0, Cond_Pass}, 32'h0);
    Cond = 4'b0100; #1 check("lit_mi", {31'd0, Cond_Pass}, 32'h1);

    // Freeze for three cycles with toggling inputs; sweep the condition field meanwhile.
    Freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, i[0], 0, 1, 1, 32'h100 + i, 4'(i + 2), 32'hA0 + i, 4'(i + 10));
      Cond = 4'(i);
      cycle();
    end
    check("lit_frz_sr", {28'd0, SR}, 32'h9);
    check("lit_frz_alu", ALU_Res, 32'h48);
    Freeze = 1'b0;
    drive(1, 0, 0, 1, 1, 32'h0000_0080, 4'b0010, 32'hCAFE_0001, 4'd3);
    cycle();
    check("lit_rel_alu", ALU_Res, 32'h80);
    check("lit_rel_w", {31'd0, MEM_W_EN}, 32'h1);

    // Cond sweep over all codes at SR=0010 (frozen so SR is stable).
    Freeze = 1'b1;
    for (int c = 0; c < 16; c++) begin
      Cond = 4'(c);
      cycle();
    end
    Freeze = 1'b0;

    // Bubble after the store.
    drive(0, 1, 0, 1, 1, 32'h0000_0999, 4'b1111, 32'h0, 4'd1);
    cycle();
    check("lit_bub_w", {31'd0, MEM_W_EN}, 32'h0);
    check("lit_bub_valid", {31'd0, MEM_Valid}, 32'h0);
    check("lit_bub_alu", ALU_Res, 32'h80);
    check("lit_bub_sr", {28'd0, SR}, 32'h2);

    // Rejected load+store.
    drive(1, 1, 1, 1, 1, 32'h0000_0555, 4'b1111, 32'h0, 4'd2);
    cycle();
    check("lit_ill_pulse", {31'd0, Illegal}, 32'h1);
    check("lit_ill_r", {31'd0, MEM_R_EN}, 32'h0);
    check("lit_ill_sr", {28'd0, SR}, 32'h2);
    drive(0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 4'd0);
    cycle();
    check("lit_ill_end", {31'd0, Illegal}, 32'h0);
    Freeze = 1'b1;
    drive(1, 1, 1, 1, 1, 32'h0000_0555, 4'b1111, 32'h0, 4'd2);
    cycle();
    check("lit_ill_frz", {31'd0, Illegal}, 32'h0);

    // Back-to-back captures with mixed flags.
    Freeze = 1'b0;
    drive(1, 1, 1, 0, 1, 32'h1111_0000, 4'b0110, 32'h2222, 4'd12);
    cycle();
    drive(1, 0, 0, 0, 0, 32'h3333_0000, 4'b1000, 32'h4444, 4'd13);
    cycle();
    check("lit_b2b_sr", {28'd0, SR}, 32'h6);
    cycle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
